// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared widths, NOP encoding and fetch FSM states
package rv_pkg;

  localparam int XLEN   = 64;
  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_END   = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO with flush
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 96
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign head_data = mem[rd_ptr];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

  // Pointer and occupancy tracking; flush discards everything at once.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - fetch sequencer between PC and instruction memory
module imem_fetch_ctrl
  import rv_pkg::*;
#(
  parameter int                ADDR_W     = XLEN,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                MEM_BYTES  = 80,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [INST_W-1:0] inst_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [INST_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  output logic              fetch_end,
  output logic              misalign_err
);

  localparam int DW = ADDR_W + INST_W;

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] fetch_pc, pc_next;
  logic              err_set;
  logic              push, pop, flush;
  logic              fifo_full, fifo_empty;
  logic [DW-1:0]     head_data;
  logic [ADDR_W:0]   pc_plus3;
  logic              in_range;
  logic              misaligned;

  // One extra bit so a PC near the top of the address space cannot wrap into range.
  assign pc_plus3   = {1'b0, fetch_pc} + (ADDR_W+1)'(3);
  assign in_range   = (pc_plus3 < (ADDR_W+1)'(MEM_BYTES));
  assign misaligned = (redirect_pc[1:0] != 2'b00);

  assign inst_addr    = fetch_pc;
  assign if_valid     = !fifo_empty && !redirect_valid && (state != ST_FAULT);
  assign pop          = if_valid && if_ready;
  assign if_pc        = head_data[DW-1:INST_W];
  assign if_inst      = if_valid ? head_data[INST_W-1:0] : NOP;
  assign fetch_end    = (state == ST_END);

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data ({fetch_pc, inst_data}),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State, fetch PC and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      fetch_pc     <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      state    <= state_next;
      fetch_pc <= pc_next;
      if (err_set) misalign_err <= 1'b1;
    end
  end

  // Next state and fetch decision; a redirect outranks any fetch in that cycle.
  always_comb begin
    state_next = state;
    pc_next    = fetch_pc;
    push       = 1'b0;
    flush      = 1'b0;
    err_set    = 1'b0;
    if (state == ST_FAULT) begin
      flush = 1'b1;
    end else if (redirect_valid) begin
      flush = 1'b1;
      if (misaligned) begin
        err_set    = 1'b1;
        state_next = ST_FAULT;
      end else begin
        pc_next    = redirect_pc;
        state_next = ST_RUN;
      end
    end else begin
      case (state)
        ST_IDLE: state_next = ST_RUN;
        ST_RUN: begin
          if (!in_range) begin
            state_next = ST_END;
          end else if (!fifo_full || pop) begin
            push    = 1'b1;
            pc_next = fetch_pc + ADDR_W'(4);
          end
        end
        default: state_next = state;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - randomized bench against a queue-based fetch model
module tb_imem_fetch_ctrl;

  localparam int          DEPTH = 2;
  localparam logic [63:0] MEMB  = 64'd80;
  localparam int M_IDLE = 0, M_RUN = 1, M_END = 2, M_FAULT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] inst_addr;
  logic [31:0] inst_data;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic        fetch_end;
  logic        misalign_err;

  logic [31:0] mem [32];

  imem_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .inst_addr      (inst_addr),
    .inst_data      (inst_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .fetch_end      (fetch_end),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (inst_addr < MEMB) inst_data = mem[inst_addr[6:2]];
    else                  inst_data = 32'hDEAD_BEEF;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  int          m_mode  = M_IDLE;
  logic [63:0] m_pc    = '0;
  bit          m_err   = 1'b0;
  bit          m_known = 1'b0;

  logic [63:0] pop_log[$];
  bit          last_valid, last_end, last_err;
  logic [63:0] last_addr;

  task automatic cycle(input bit rst, input bit rdy, input bit rv, input logic [63:0] rpc);
    bit   exp_valid, pop, full, mis;
    ent_t e;
    reset = rst; if_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    #1;
    last_valid = if_valid; last_end = fetch_end; last_err = misalign_err; last_addr = inst_addr;
    if (if_valid === 1'b1 && if_ready) pop_log.push_back(if_pc);
    exp_valid = m_known && (mq.size() > 0) && !rv && (m_mode != M_FAULT);
    if (m_known) begin
      chk("inst_addr", inst_addr, m_pc);
      chk("if_valid", 64'(if_valid), 64'(exp_valid));
      chk("fetch_end", 64'(fetch_end), 64'(m_mode == M_END));
      chk("misalign_err", 64'(misalign_err), 64'(m_err));
      if (exp_valid) begin
        chk("if_pc", if_pc, mq[0].pc);
        chk("if_inst", 64'(if_inst), 64'(mq[0].inst));
      end
    end
    pop = exp_valid && rdy;
    mis = rv && (rpc[1:0] != 2'b00);
    if (rst) begin
      m_known = 1'b1; m_mode = M_IDLE; m_pc = '0; m_err = 1'b0; mq.delete();
    end else if (m_known && m_mode != M_FAULT) begin
      if (rv) begin
        mq.delete();
        if (mis) begin m_err = 1'b1; m_mode = M_FAULT; end
        else begin m_pc = rpc; m_mode = M_RUN; end
      end else if (m_mode == M_IDLE) begin
        m_mode = M_RUN;
      end else begin
        full = (mq.size() == DEPTH);
        if (pop) void'(mq.pop_front());
        if (m_mode == M_RUN) begin
          if (m_pc + 64'd3 < MEMB) begin
            if (!full || pop) begin
              e.pc = m_pc; e.inst = mem[m_pc[6:2]];
              mq.push_back(e);
              m_pc = m_pc + 64'd4;
            end
          end else begin
            m_mode = M_END;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] tgt;
    bit rst, rv, rdy;
    int n;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;

    // Full image streamed with decode always ready.
    cycle(1, 1, 0, 0); cycle(1, 1, 0, 0);
    pop_log.delete();
    for (int i = 0; i < 25; i++) cycle(0, 1, 0, 0);
    chk("stream_len", 64'(pop_log.size()), 64'd20);
    for (int i = 0; i < 20 && i < pop_log.size(); i++) chk("stream_pc", pop_log[i], 64'(i * 4));
    chk("stream_end", 64'(last_end), 64'd1);
    chk("stream_drained", 64'(last_valid), 64'd0);

    // Decode stall at pc 8.
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
    chk("stall_fetch_pc", inst_addr, 64'h10);
    chk("stall_head", if_pc, 64'h8);
    pop_log.delete();
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
    chk("stall_order_len", 64'(pop_log.size()), 64'd3);
    for (int i = 0; i < 3 && i < pop_log.size(); i++) chk("stall_order", pop_log[i], 64'(8 + i * 4));

    // Redirect masks a head at 0x10.
    cycle(0, 0, 1, 64'h10);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("head_before_redir", if_pc, 64'h10);
    pop_log.delete();
    cycle(0, 1, 1, 64'h1C);
    chk("redir_mask", 64'(last_valid), 64'd0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);
    chk("redir_first", pop_log.size() > 0 ? pop_log[0] : 64'hFFFF_FFFF, 64'h1C);

    // Redirect out of END.
    n = 0;
    while (!last_end && n < 40) begin cycle(0, 1, 0, 0); n++; end
    chk("reach_end", 64'(last_end), 64'd1);
    pop_log.delete();
    cycle(0, 1, 1, 64'h30);
    cycle(0, 1, 0, 0);
    chk("end_drop", 64'(last_end), 64'd0);
    for (int i = 0; i < 12; i++) cycle(0, 1, 0, 0);
    chk("resume_len", 64'(pop_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < pop_log.size(); i++) chk("resume_pc", pop_log[i], 64'(48 + i * 4));
    chk("resume_end", 64'(last_end), 64'd1);

    // Misaligned redirect is sticky until reset.
    cycle(0, 1, 1, 64'h22);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);
    chk("misalign_set", 64'(last_err), 64'd1);
    chk("misalign_valid", 64'(last_valid), 64'd0);
    cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    chk("misalign_clear", 64'(last_err), 64'd0);

    // Reset while full and popping.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
    chk("full_before_reset", 64'(last_valid), 64'd1);
    cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    chk("rst_pc", last_addr, 64'h0);
    chk("rst_empty", 64'(last_valid), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0) || (m_mode == M_FAULT && $urandom_range(0, 19) == 0);
      rv  = ($urandom_range(0, 11) == 0);
      tgt = 64'($urandom_range(0, 22)) << 2;
      if ($urandom_range(0, 7) == 0) tgt = tgt + 64'($urandom_range(1, 3));
      rdy = ($urandom_range(0, 9) < 7);
      cycle(rst, rdy, rv, tgt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
